// File: rtl/dds_multi_ch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_multi_ch_ctrl
// Description : AXI4-Lite control for a multi-channel DDS. Holds shadow FTWs
//               with an atomic commit and runs per-channel phase accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_multi_ch_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_CH             = 8,
    parameter int PHASE_W            = 32
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              sample_tick,
    output logic [NUM_CH*PHASE_W-1:0]         phase_out,
    output logic                              commit_pending
);

    localparam int DW          = C_S_AXI_DATA_WIDTH;
    localparam int AW          = C_S_AXI_ADDR_WIDTH;
    localparam int c_CTRL_WORD = 0;
    localparam int c_STAT_WORD = 1;
    localparam int c_FTW_BASE  = 16;

    logic                r_wr_ready;
    logic                r_bvalid;
    logic                r_arready;
    logic                r_rvalid;
    logic [DW-1:0]       r_rdata;
    logic                r_enable;
    logic                r_commit_pending;
    logic                r_clr_pending;
    logic [PHASE_W-1:0]  r_shadow [NUM_CH];

    logic                w_wr_fire;
    logic                w_rd_fire;
    logic                w_ctrl_wr;
    logic                w_tick_en;
    logic                w_xfer;
    logic                w_clr;
    int                  w_wr_word;
    int                  w_rd_word;
    logic [DW-1:0]       w_rd_data;
    logic                w_unused;

    function automatic logic [DW-1:0] f_merge(
        input logic [DW-1:0]   old_val,
        input logic [DW-1:0]   new_val,
        input logic [DW/8-1:0] strb
    );
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < DW/8; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign w_unused   = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign w_wr_word  = 32'(S_AXI_AWADDR[AW-1:2]);
    assign w_rd_word  = 32'(S_AXI_ARADDR[AW-1:2]);
    assign w_wr_fire  = r_wr_ready & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_fire  = r_arready & S_AXI_ARVALID;
    assign w_ctrl_wr  = w_wr_fire & (w_wr_word == c_CTRL_WORD) & S_AXI_WSTRB[0];
    assign w_tick_en  = sample_tick & r_enable;
    // With the accumulators stopped there is no sample boundary to wait for.
    assign w_xfer     = r_commit_pending & (w_tick_en | ~r_enable);
    assign w_clr      = r_clr_pending & (w_tick_en | ~r_enable);

    assign S_AXI_AWREADY  = r_wr_ready;
    assign S_AXI_WREADY   = r_wr_ready;
    assign S_AXI_BVALID   = r_bvalid;
    assign S_AXI_BRESP    = 2'b00;
    assign S_AXI_ARREADY  = r_arready;
    assign S_AXI_RVALID   = r_rvalid;
    assign S_AXI_RDATA    = r_rdata;
    assign S_AXI_RRESP    = 2'b00;
    assign commit_pending = r_commit_pending;

    always_comb begin
        w_rd_data = '0;
        if (w_rd_word == c_CTRL_WORD) begin
            w_rd_data[0] = r_enable;
        end else if (w_rd_word == c_STAT_WORD) begin
            w_rd_data[1:0] = {r_clr_pending, r_commit_pending};
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_rd_word == c_FTW_BASE + c) w_rd_data = DW'(r_shadow[c]);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wr_ready <= 1'b0;
            r_bvalid   <= 1'b0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_wr_ready <= ~r_wr_ready & ~r_bvalid & S_AXI_AWVALID & S_AXI_WVALID;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
            end else if (S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
            r_arready <= ~r_arready & ~r_rvalid & S_AXI_ARVALID;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // A transfer always clears the pending flag, so a commit arriving while
    // one is pending folds into that single transfer.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_enable         <= 1'b0;
            r_commit_pending <= 1'b0;
            r_clr_pending    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_enable <= S_AXI_WDATA[0];
            if (w_xfer) begin
                r_commit_pending <= 1'b0;
            end else if (w_ctrl_wr && S_AXI_WDATA[1]) begin
                r_commit_pending <= 1'b1;
            end
            if (w_clr) begin
                r_clr_pending <= 1'b0;
            end else if (w_ctrl_wr && S_AXI_WDATA[2]) begin
                r_clr_pending <= 1'b1;
            end
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [PHASE_W-1:0] r_active;
            logic [PHASE_W-1:0] r_acc;
            logic [DW-1:0]      w_merged;
            logic               w_sel;

            assign w_sel    = w_wr_fire & (w_wr_word == c_FTW_BASE + c);
            assign w_merged = f_merge(DW'(r_shadow[c]), S_AXI_WDATA, S_AXI_WSTRB);

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    r_shadow[c] <= '0;
                    r_active    <= '0;
                    r_acc       <= '0;
                end else begin
                    if (w_sel) r_shadow[c] <= w_merged[PHASE_W-1:0];
                    if (w_xfer) r_active <= r_shadow[c];
                    if (w_clr) begin
                        r_acc <= '0;
                    end else if (w_tick_en) begin
                        r_acc <= r_acc + r_active;
                    end
                end
            end

            assign phase_out[c*PHASE_W +: PHASE_W] = r_acc;
        end
    endgenerate

endmodule
`default_nettype wire
